// File: rtl/axi_read_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_read_master
// Brief    : Single-outstanding AXI read initiator. Issues one AR burst per line
//            request, gathers R beats into a line buffer, returns line + error.
// Revision : 1.0
// ============================================================================
module axi_read_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [ADDR_WIDTH-1:0]           req_addr,
  input  logic [LEN_WIDTH-1:0]            req_len,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic [MAX_BEATS*DATA_WIDTH-1:0] resp_data,
  output logic                            resp_err,
  output logic                            m_arvalid,
  input  logic                            m_arready,
  output logic [ADDR_WIDTH-1:0]           m_araddr,
  output logic [LEN_WIDTH-1:0]            m_arlen,
  input  logic                            m_rvalid,
  output logic                            m_rready,
  input  logic [DATA_WIDTH-1:0]           m_rdata,
  input  logic [1:0]                      m_rresp,
  input  logic                            m_rlast
);

  localparam int                   c_cnt_w     = $clog2(MAX_BEATS) + 1;
  localparam logic [LEN_WIDTH-1:0] c_max_len   = LEN_WIDTH'(MAX_BEATS - 1);
  localparam logic [1:0]           c_resp_okay = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_AR    = 2'd1,
    S_RDATA = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                          state_q;
  logic                            m_arvalid_q;
  logic                            m_rready_q;
  logic                            resp_valid_q;
  logic                            resp_err_q,  resp_err_d;
  logic [ADDR_WIDTH-1:0]           m_araddr_q;
  logic [LEN_WIDTH-1:0]            m_arlen_q;
  logic [MAX_BEATS*DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic [c_cnt_w-1:0]              cnt_q,       cnt_d;

  logic                 w_req_fire;
  logic                 w_beat_fire;
  logic [LEN_WIDTH-1:0] w_cnt_ext;
  logic                 w_in_range;
  logic                 w_last_slot;
  logic                 w_early_last;
  logic                 w_overrun;
  logic                 w_beat_err;
  logic [LEN_WIDTH-1:0] w_clamped_len;
  logic                 w_unused;

  assign w_req_fire    = req_valid && (state_q == S_IDLE);
  assign w_beat_fire   = (state_q == S_RDATA) && m_rvalid && m_rready_q;
  assign w_cnt_ext     = LEN_WIDTH'(cnt_q);
  // Compare as cnt <= arlen so arlen+1 can never overflow the field.
  assign w_in_range    = (w_cnt_ext <= m_arlen_q);
  assign w_last_slot   = (w_cnt_ext == m_arlen_q);
  assign w_early_last  = m_rlast && (w_cnt_ext < m_arlen_q);
  assign w_overrun     = !m_rlast && w_last_slot;
  assign w_beat_err    = (m_rresp != c_resp_okay) || w_early_last || w_overrun;
  assign w_clamped_len = (req_len > c_max_len) ? c_max_len : req_len;

  // Byte offset inside the word is dropped by alignment.
  assign w_unused = ^req_addr[1:0];

  always_comb begin
    resp_data_d = resp_data_q;
    cnt_d       = cnt_q;
    resp_err_d  = resp_err_q;
    if (w_req_fire) begin
      resp_data_d = '0;
      cnt_d       = '0;
      resp_err_d  = 1'b0;
    end else if (w_beat_fire) begin
      if (w_in_range) begin
        for (int i = 0; i < MAX_BEATS; i++) begin
          if (cnt_q == c_cnt_w'(i)) begin
            resp_data_d[i*DATA_WIDTH +: DATA_WIDTH] = m_rdata;
          end
        end
        cnt_d = cnt_q + 1'b1;
      end
      if (w_beat_err) begin
        resp_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      m_arvalid_q  <= 1'b0;
      m_rready_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      m_araddr_q   <= '0;
      m_arlen_q    <= '0;
      resp_data_q  <= '0;
      cnt_q        <= '0;
    end else begin
      resp_data_q <= resp_data_d;
      cnt_q       <= cnt_d;
      resp_err_q  <= resp_err_d;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            m_araddr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            m_arlen_q   <= w_clamped_len;
            m_arvalid_q <= 1'b1;
            state_q     <= S_AR;
          end
        end
        S_AR: begin
          if (m_arready) begin
            m_arvalid_q <= 1'b0;
            m_rready_q  <= 1'b1;
            state_q     <= S_RDATA;
          end
        end
        S_RDATA: begin
          // Any rlast ends the burst: normal, early, or after an overrun.
          if (w_beat_fire && m_rlast) begin
            m_rready_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign m_arvalid  = m_arvalid_q;
  assign m_araddr   = m_araddr_q;
  assign m_arlen    = m_arlen_q;
  assign m_rready   = m_rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_read_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_read_master
// Brief    : Table-driven, scoreboard-checked bench for axi_read_master.
// Revision : 1.0
// ============================================================================
module tb_axi_read_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 8;
  localparam int LW = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [AW-1:0]    req_addr;
  logic [LW-1:0]    req_len;
  logic             resp_valid;
  logic             resp_ready;
  logic [MB*DW-1:0] resp_data;
  logic             resp_err;
  logic             m_arvalid;
  logic             m_arready;
  logic [AW-1:0]    m_araddr;
  logic [LW-1:0]    m_arlen;
  logic             m_rvalid;
  logic             m_rready;
  logic [DW-1:0]    m_rdata;
  logic [1:0]       m_rresp;
  logic             m_rlast;

  axi_read_master #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_BEATS (MB),
    .LEN_WIDTH (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_araddr  (m_araddr),
    .m_arlen   (m_arlen),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rlast   (m_rlast)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0]    addr;
    logic [LW-1:0]    len;
    int               delay;
    int               nbeats;
    int               errbeat;
    int               hold;
    logic [AW-1:0]    exp_araddr;
    logic [LW-1:0]    exp_arlen;
    logic [MB*DW-1:0] exp_data;
    logic             exp_err;
  } vec_t;

  typedef struct {
    logic [AW-1:0]    araddr;
    logic [LW-1:0]    arlen;
    logic [MB*DW-1:0] data;
    logic             err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];

  task automatic chk(input string name, input logic [MB*DW-1:0] act, input logic [MB*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat(input int k);
    return DW'(32'h11 * (k + 1));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    exp_t             e;
    exp_t             got;
    logic [MB*DW-1:0] held;
    chk($sformatf("v%0d_req_ready_idle", id), req_ready, 1);
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_len   = v.len;
    tick();
    req_valid = 1'b0;
    e.araddr = v.exp_araddr;
    e.arlen  = v.exp_arlen;
    e.data   = v.exp_data;
    e.err    = v.exp_err;
    sb.push_back(e);
    chk($sformatf("v%0d_accept_data_clr", id), resp_data, 0);
    chk($sformatf("v%0d_accept_err_clr", id), resp_err, 0);
    chk($sformatf("v%0d_req_ready_busy", id), req_ready, 0);
    for (int d = 0; d < v.delay; d++) begin
      chk($sformatf("v%0d_arvalid_hold%0d", id, d), m_arvalid, 1);
      chk($sformatf("v%0d_araddr_hold%0d", id, d), m_araddr, sb[0].araddr);
      chk($sformatf("v%0d_arlen_hold%0d", id, d), m_arlen, sb[0].arlen);
      chk($sformatf("v%0d_rready_in_ar%0d", id, d), m_rready, 0);
      tick();
    end
    chk($sformatf("v%0d_arvalid", id), m_arvalid, 1);
    chk($sformatf("v%0d_araddr", id), m_araddr, sb[0].araddr);
    chk($sformatf("v%0d_arlen", id), m_arlen, sb[0].arlen);
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    chk($sformatf("v%0d_arvalid_drop", id), m_arvalid, 0);
    chk($sformatf("v%0d_rready_up", id), m_rready, 1);
    for (int k = 0; k < v.nbeats; k++) begin
      m_rvalid = 1'b1;
      m_rdata  = beat(k);
      m_rresp  = (k == v.errbeat) ? 2'b10 : 2'b00;
      m_rlast  = (k == v.nbeats - 1);
      tick();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    m_rresp  = 2'b00;
    chk($sformatf("v%0d_resp_valid", id), resp_valid, 1);
    chk($sformatf("v%0d_rready_down", id), m_rready, 0);
    held = resp_data;
    for (int h = 0; h < v.hold; h++) begin
      tick();
      chk($sformatf("v%0d_hold_valid%0d", id, h), resp_valid, 1);
      chk($sformatf("v%0d_hold_data%0d", id, h), resp_data, held);
      chk($sformatf("v%0d_hold_req_ready%0d", id, h), req_ready, 0);
    end
    resp_ready = 1'b1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL v%0d_scoreboard_empty actual=0 expected=1", id);
    end else begin
      got = sb.pop_front();
      chk($sformatf("v%0d_resp_data", id), resp_data, got.data);
      chk($sformatf("v%0d_resp_err", id), resp_err, got.err);
      chk($sformatf("v%0d_araddr_done", id), m_araddr, got.araddr);
      chk($sformatf("v%0d_arlen_done", id), m_arlen, got.arlen);
    end
    chk($sformatf("v%0d_req_ready_done", id), req_ready, 0);
    tick();
    resp_ready = 1'b0;
    chk($sformatf("v%0d_resp_valid_clr", id), resp_valid, 0);
    chk($sformatf("v%0d_req_ready_back", id), req_ready, 1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_arvalid"}, m_arvalid, 0);
    chk({tag, "_rready"}, m_rready, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_err"}, resp_err, 0);
    chk({tag, "_araddr"}, m_araddr, 0);
    chk({tag, "_arlen"}, m_arlen, 0);
    chk({tag, "_resp_data"}, resp_data, 0);
    chk({tag, "_req_ready"}, req_ready, 1);
  endtask

  initial begin
    //        addr          len    dly nb err hold araddr        arlen  data                                                                             err
    vecs[0] = '{32'h0000_0010, 8'd3,  0, 4, -1, 3, 32'h0000_0010, 8'd3, 256'h00000044_00000033_00000022_00000011, 1'b0};
    vecs[1] = '{32'h0000_0106, 8'd20, 0, 8, -1, 0, 32'h0000_0104, 8'd7,
                256'h00000088_00000077_00000066_00000055_00000044_00000033_00000022_00000011, 1'b0};
    vecs[2] = '{32'h0000_0200, 8'd3,  5, 4, -1, 0, 32'h0000_0200, 8'd3, 256'h00000044_00000033_00000022_00000011, 1'b0};
    vecs[3] = '{32'h0000_0300, 8'd3,  0, 4,  1, 0, 32'h0000_0300, 8'd3, 256'h00000044_00000033_00000022_00000011, 1'b1};
    vecs[4] = '{32'h0000_0400, 8'd3,  0, 2, -1, 0, 32'h0000_0400, 8'd3, 256'h00000022_00000011, 1'b1};
    vecs[5] = '{32'h0000_0440, 8'd1,  0, 4, -1, 1, 32'h0000_0440, 8'd1, 256'h00000022_00000011, 1'b1};
    vecs[6] = '{32'h0000_0003, 8'd0,  0, 1, -1, 0, 32'h0000_0000, 8'd0, 256'h00000011, 1'b0};

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_len    = '0;
    resp_ready = 1'b0;
    m_arready  = 1'b0;
    m_rvalid   = 1'b0;
    m_rdata    = '0;
    m_rresp    = 2'b00;
    m_rlast    = 1'b0;
    tick();
    chk_reset_state("por");
    rst = 1'b0;
    tick();

    // Stray R traffic while idle must be ignored.
    m_rvalid = 1'b1;
    m_rlast  = 1'b1;
    m_rdata  = 32'hDEAD_BEEF;
    m_rresp  = 2'b11;
    tick();
    tick();
    chk("idle_rvalid_ready", m_rready, 0);
    chk("idle_rvalid_resp", resp_valid, 0);
    chk("idle_rvalid_err", resp_err, 0);
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    m_rresp  = 2'b00;

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset in the middle of a data phase aborts with no response.
    req_valid = 1'b1;
    req_addr  = 32'h0000_0500;
    req_len   = 8'd3;
    tick();
    req_valid = 1'b0;
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    chk("mid_rready", m_rready, 1);
    for (int k = 0; k < 2; k++) begin
      m_rvalid = 1'b1;
      m_rdata  = beat(k);
      m_rresp  = (k == 1) ? 2'b10 : 2'b00;
      m_rlast  = 1'b0;
      tick();
    end
    m_rvalid = 1'b0;
    m_rresp  = 2'b00;
    chk("mid_err_before_rst", resp_err, 1);
    chk("mid_data_before_rst", resp_data, 256'h00000022_00000011);
    rst = 1'b1;
    #1;
    chk_reset_state("mid_rst");
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_no_resp", resp_valid, 0);
    run_vec(vecs[6], 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/axi_read_master.md
Name: axi_read_master

Overview:
- Initiator side of the AXI read channel used by the instruction memory and by other AXI read slaves.
- A client (fetch unit / I-cache refill) posts a single-line read request. The block issues one AR burst, collects the R beats into a line buffer, then returns the whole line with an error flag.
- Exactly one outstanding transaction at a time.

Parameters:
- ADDR_WIDTH, 32, address width; matches the `_riscv_defines` value.
- DATA_WIDTH, 32, R-channel beat width in bits.
- MAX_BEATS, 8, line buffer depth in beats. Maximum burst is MAX_BEATS beats.
- LEN_WIDTH, 8, width of the arlen / req_len fields.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  client request strobe.
- req_ready  output  1  block can accept a request.
- req_addr  input  ADDR_WIDTH  byte address of the line.
- req_len  input  LEN_WIDTH  beats minus 1.
- resp_valid  output  1  line data and error flag are valid.
- resp_ready  input  1  client consumes the response.
- resp_data  output  MAX_BEATS*DATA_WIDTH  line buffer; beat i is at [i*DATA_WIDTH +: DATA_WIDTH].
- resp_err  output  1  transaction had a protocol or response error.
- m_arvalid  output  1  AR valid.
- m_arready  input  1  AR ready.
- m_araddr  output  ADDR_WIDTH  AR address.
- m_arlen  output  LEN_WIDTH  AR burst length minus 1.
- m_rvalid  input  1  R valid.
- m_rready  output  1  R ready.
- m_rdata  input  DATA_WIDTH  R data.
- m_rresp  input  2  R response.
- m_rlast  input  1  R last beat.

Behaviour:
- FSM states and transitions:
  - IDLE -> AR on req_valid.
  - AR -> RDATA on m_arvalid && m_arready.
  - RDATA -> DONE on an accepted beat (m_rvalid && m_rready) with m_rlast=1.
  - DONE -> IDLE on resp_ready.
- Reset values (rst=1, takes effect immediately and asynchronously):
  - state=IDLE, m_arvalid=0, m_rready=0, resp_valid=0, resp_err=0.
  - m_araddr=0, m_arlen=0, resp_data=0, beat counter=0.
  - Reset in any state aborts the transaction with no response.
- req_ready = (state==IDLE). A request is accepted on req_valid && req_ready.
- Registers captured on accept:
  - m_araddr = {req_addr[ADDR_WIDTH-1:2], 2'b00}, i.e. word-aligned.
  - m_arlen = min(req_len, MAX_BEATS-1). The clamp is silent and does not set resp_err.
  - resp_data is cleared to 0, resp_err to 0, and the beat counter to 0.
- AR state:
  - m_arvalid=1 and held until m_arready is sampled high.
  - m_araddr and m_arlen stay stable from accept until return to IDLE, because the slave may sample arlen during the R phase.
- RDATA state:
  - m_rready=1 for the whole state; m_rready=0 in all other states.
  - Each accepted beat with counter < m_arlen+1 writes m_rdata to slot counter, then counter increments.
  - Counter width is clog2(MAX_BEATS)+1 and never wraps inside a burst.
  - Any accepted beat with m_rresp != 2'b00 (AXI_RESP_OKAY) sets resp_err (sticky until the next accept).
  - Early rlast (m_rlast=1 while counter < m_arlen) stores that beat, sets resp_err, and goes to DONE.
  - Overrun: slot m_arlen accepted with m_rlast=0 sets resp_err. Further beats are discarded and not written until m_rlast; then DONE.
  - m_rvalid while not in RDATA is ignored.
- DONE state:
  - resp_valid=1; resp_data and resp_err are held stable until resp_ready.
  - Leaving DONE clears resp_valid on the next edge.
  - req_ready stays 0 in DONE, so no new request is accepted in the same cycle resp_ready is high.
- Latency: accept at edge N gives m_arvalid high from N+1. Earliest resp_valid is one cycle after the rlast beat is accepted.

Test Plan:
- Basic burst: req_addr=0x0000_0010, req_len=3; slave returns 0x11,0x22,0x33,0x44 with rlast on the 4th beat. Required: m_araddr=0x10, m_arlen=3, resp_data[127:0]=0x00000044_00000033_00000022_00000011, upper slots 0, resp_err=0, resp_valid one cycle after rlast.
- Unaligned and clamp: req_addr=0x0000_0106, req_len=20. Required: m_araddr=0x104, m_arlen=7; an 8-beat burst completes with resp_err=0.
- AR backpressure: m_arready held low 5 cycles. Required: m_arvalid stays 1 and m_araddr/m_arlen stay stable; handshake on cycle 6 gives m_rready=1 next cycle.
- Errors:
  - m_rresp=2'b10 on beat 1 of 4 gives resp_err=1 and all 4 beats stored.
  - Separately, rlast on beat 2 of a req_len=3 burst gives resp_err=1, slots 2-3 = 0, and DONE reached.
- Response hold and back-to-back: resp_ready low 3 cycles keeps resp_valid and resp_data stable and req_ready=0. After release, a second request accepted in IDLE starts with resp_data cleared.
- Reset mid-burst: assert rst during RDATA after 2 beats. Required: all outputs return to reset values immediately; after deassert, a fresh req_len=0 read completes normally.
